memory_arbiter: RTL

Sequential arbiter that shares the single-port RAM between the instruction-fetch path and the data-access path of the datapath. It accepts fetch requests (iREN) and load/store requests (dREN/dWEN, as driven by the control unit) and grants one requester at a time. It steers address, store data and enables to RAM and returns ihit/dhit and load data. Data requests have priority, bounded by an anti-starvation counter so that fetch always makes progress.

---
 rtl/memory_arbiter_pkg.sv | 4 +
 rtl/memory_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/memory_arbiter_pkg.sv
// RAM status encoding shared by the arbiter and anything driving it.
package memory_arbiter_pkg;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-port RAM between instruction fetch and data access; data wins
// unless a pending fetch has been passed over STARVE_LIMIT times. Hit >= 2 cycles after request.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  ramstate_t   ramstate,
    input  logic [31:0] ramload,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        err
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt, starve_nxt;
    logic          err_nxt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            err        <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        err_nxt    = err;
        ihit       = 1'b0;
        iload      = '0;
        dhit       = 1'b0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        unique case (state)
            IDLE: begin
                // A fetch passed over LIMIT times in a row takes the next slot.
                if ((dREN || dWEN) && !(iREN && starve_cnt == LIMIT)) begin
                    state_nxt = DGRANT;
                    if (iREN)
                        starve_nxt = starve_cnt + CW'(1);
                end else if (iREN) begin
                    state_nxt  = IGRANT;
                    starve_nxt = '0;
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_nxt = IDLE;
                end else if (ramstate == ACCESS) begin
                    ihit      = 1'b1;
                    iload     = ramload;
                    state_nxt = IDLE;
                end else if (ramstate == ERROR) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end

            DGRANT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (!(dREN || dWEN)) begin
                    state_nxt = IDLE;
                end else if (ramstate == ACCESS) begin
                    dhit      = 1'b1;
                    dload     = dWEN ? '0 : ramload;
                    state_nxt = IDLE;
                end else if (ramstate == ERROR) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule
